// File: rtl/voice_pitch_scheduler.sv
// Round-robin scheduler that shares one fixed-latency note-to-DDS converter among all voices.
// A voice is queued when its note or the shared pitch wheel changes, and its result is latched afterwards.
module voice_pitch_scheduler #(
  parameter int unsigned VOICES   = 8,
  parameter int unsigned CONV_LAT = 6,
  localparam int unsigned VW      = $clog2(VOICES)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7*VOICES-1:0]    VOICE_NOTE,
  input  logic [13:0]            PITCH,
  output logic [6:0]             CONV_NOTE,
  output logic [13:0]            CONV_PITCH,
  input  logic [31:0]            CONV_ADDER,
  output logic [32*VOICES-1:0]   ADDER_OUT,
  output logic                   UPD_STB,
  output logic [VW-1:0]          UPD_VOICE,
  output logic                   BUSY
);

  localparam int unsigned CntW = $clog2(CONV_LAT);
  localparam logic [CntW-1:0] CntLoad = CntW'(CONV_LAT - 1);
  localparam logic [13:0] PitchCentre = 14'd8192;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   ptr_q, ptr_d;
  logic [VW-1:0]   v_q, v_d;
  logic            fresh_q, fresh_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [VOICES-1:0] dirty_q, dirty_d;
  logic [6:0]      note_snap_q [VOICES];
  logic [6:0]      note_snap_d [VOICES];
  logic [13:0]     pitch_snap_q, pitch_snap_d;
  logic [6:0]      conv_note_q, conv_note_d;
  logic [13:0]     conv_pitch_q, conv_pitch_d;
  logic [31:0]     adder_q [VOICES];
  logic [31:0]     adder_d [VOICES];
  logic            upd_stb_q, upd_stb_d;
  logic [VW-1:0]   upd_voice_q, upd_voice_d;

  logic [6:0]      note_in [VOICES];
  logic            sel_found;
  logic [VW-1:0]   sel_idx;
  int unsigned     sel_probe;

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    assign note_in[g]            = VOICE_NOTE[7*g +: 7];
    assign ADDER_OUT[32*g +: 32] = adder_q[g];
  end

  // Search starts just past the last stored voice; straight after reset nothing has been
  // stored yet, so the search starts at ptr itself and the first pass runs 0..VOICES-1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_probe = 0;
    for (int unsigned k = 0; k < VOICES; k++) begin
      sel_probe = int'(ptr_q) + k + (fresh_q ? 0 : 1);
      if (sel_probe >= VOICES) sel_probe = sel_probe - VOICES;
      if (!sel_found && dirty_q[VW'(sel_probe)]) begin
        sel_found = 1'b1;
        sel_idx   = VW'(sel_probe);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    v_d          = v_q;
    fresh_d      = fresh_q;
    cnt_d        = cnt_q;
    dirty_d      = dirty_q;
    note_snap_d  = note_snap_q;
    pitch_snap_d = PITCH;
    conv_note_d  = conv_note_q;
    conv_pitch_d = conv_pitch_q;
    adder_d      = adder_q;
    upd_stb_d    = 1'b0;
    upd_voice_d  = upd_voice_q;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          v_d     = sel_idx;
          state_d = StIssue;
        end
      end
      StIssue: begin
        conv_note_d      = note_in[v_q];
        conv_pitch_d     = PITCH;
        note_snap_d[v_q] = note_in[v_q];
        dirty_d[v_q]     = 1'b0;
        cnt_d            = CntLoad;
        state_d          = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StStore;
      end
      StStore: begin
        adder_d[v_q] = CONV_ADDER;
        upd_stb_d    = 1'b1;
        upd_voice_d  = v_q;
        ptr_d        = v_q;
        fresh_d      = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The issued voice is exempt in its ISSUE cycle: it is converted with the current inputs.
    for (int i = 0; i < VOICES; i++) begin
      if (!(state_q == StIssue && VW'(i) == v_q) &&
          (note_in[i] != note_snap_q[i] || PITCH != pitch_snap_q)) begin
        dirty_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      v_q          <= '0;
      fresh_q      <= 1'b1;
      cnt_q        <= '0;
      dirty_q      <= '1;
      note_snap_q  <= '{default: '0};
      pitch_snap_q <= PitchCentre;
      conv_note_q  <= '0;
      conv_pitch_q <= PitchCentre;
      adder_q      <= '{default: '0};
      upd_stb_q    <= 1'b0;
      upd_voice_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      v_q          <= v_d;
      fresh_q      <= fresh_d;
      cnt_q        <= cnt_d;
      dirty_q      <= dirty_d;
      note_snap_q  <= note_snap_d;
      pitch_snap_q <= pitch_snap_d;
      conv_note_q  <= conv_note_d;
      conv_pitch_q <= conv_pitch_d;
      adder_q      <= adder_d;
      upd_stb_q    <= upd_stb_d;
      upd_voice_q  <= upd_voice_d;
    end
  end

  assign CONV_NOTE  = conv_note_q;
  assign CONV_PITCH = conv_pitch_q;
  assign UPD_STB    = upd_stb_q;
  assign UPD_VOICE  = upd_voice_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_voice_pitch_scheduler.sv
// Scoreboard bench for voice_pitch_scheduler with a 5-edge pipelined converter stub.
module tb_voice_pitch_scheduler;

  localparam int V   = 8;
  localparam int LAT = 6;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [6:0]     notes [V];
  logic [7*V-1:0] VOICE_NOTE;
  logic [13:0]    PITCH;
  logic [6:0]     CONV_NOTE;
  logic [13:0]    CONV_PITCH;
  logic [31:0]    CONV_ADDER;
  logic [32*V-1:0] ADDER_OUT;
  logic           UPD_STB;
  logic [2:0]     UPD_VOICE;
  logic           BUSY;

  typedef struct {
    int          voice;
    logic [31:0] val;
    bit          gap;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] exp_slot [V];
  logic [20:0] conv_pipe [5] = '{default: '0};
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_stb = 0;
  exp_t        mon_e;
  logic [255:0] mon_all;

  voice_pitch_scheduler #(.VOICES(V), .CONV_LAT(LAT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .VOICE_NOTE (VOICE_NOTE),
    .PITCH      (PITCH),
    .CONV_NOTE  (CONV_NOTE),
    .CONV_PITCH (CONV_PITCH),
    .CONV_ADDER (CONV_ADDER),
    .ADDER_OUT  (ADDER_OUT),
    .UPD_STB    (UPD_STB),
    .UPD_VOICE  (UPD_VOICE),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    VOICE_NOTE = '0;
    for (int i = 0; i < V; i++) VOICE_NOTE[7*i +: 7] = notes[i];
  end

  // Converter stub: result follows operands 5 edges later.
  always @(posedge CLK) begin
    conv_pipe[0] <= {CONV_NOTE, CONV_PITCH};
    for (int i = 1; i < 5; i++) conv_pipe[i] <= conv_pipe[i-1];
  end
  assign CONV_ADDER = {11'd0, conv_pipe[4]};

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [6:0] n, input logic [13:0] p);
    return {11'd0, n, p};
  endfunction

  task automatic expect_upd(input int v, input bit gap);
    exp_t e;
    e.voice = v;
    e.val   = conv(notes[v], PITCH);
    e.gap   = gap;
    sb_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RESET && UPD_STB) begin
      if (sb_q.size() == 0) begin
        check("unexpected_stb", UPD_VOICE, V);
      end else begin
        mon_e = sb_q.pop_front();
        exp_slot[mon_e.voice] = mon_e.val;
        mon_all = '0;
        for (int i = 0; i < V; i++) mon_all[32*i +: 32] = exp_slot[i];
        check("upd_voice", UPD_VOICE, mon_e.voice);
        check("slot", ADDER_OUT[32*mon_e.voice +: 32], mon_e.val);
        check("all_slots", ADDER_OUT, mon_all);
        if (mon_e.gap) check("stb_gap", cyc - last_stb, 8);
      end
      last_stb = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (!BUSY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_busy"}, BUSY, 1);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((sb_q.size() != 0 || BUSY) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_drain"}, sb_q.size(), 0);
    check({tag, "_idle"}, BUSY, 0);
    tick(10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adder"}, ADDER_OUT, 0);
    check({tag, "_cnote"}, CONV_NOTE, 0);
    check({tag, "_cpitch"}, CONV_PITCH, 8192);
    check({tag, "_stb"}, UPD_STB, 0);
    check({tag, "_uvoice"}, UPD_VOICE, 0);
    check({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    PITCH = 14'd8192;
    for (int i = 0; i < V; i++) begin
      notes[i]    = '0;
      exp_slot[i] = '0;
    end
    tick(6);
    check_reset_outputs("reset");

    // Full refresh after reset, voices 0..7.
    for (int i = 0; i < V; i++) expect_upd(i, i > 0);
    RESET = 1'b0;
    drain("refresh");

    // Single note change.
    notes[3] = 7'd60;
    expect_upd(3, 1'b0);
    drain("note3");

    // Pitch change while idle, ptr=3.
    PITCH = 14'd10000;
    for (int k = 0; k < V; k++) expect_upd((4 + k) % V, k > 0);
    drain("pitch");

    // Voice 2 changes during its own WAIT; voice 5 also becomes dirty.
    notes[2] = 7'd40;
    expect_upd(2, 1'b0);
    wait_busy("wait2");
    tick(2);
    notes[2] = 7'd41;
    notes[5] = 7'd50;
    expect_upd(5, 1'b1);
    expect_upd(2, 1'b1);
    drain("midwait");

    // Move ptr to 5, then change voices 1 and 6 together.
    notes[5] = 7'd51;
    expect_upd(5, 1'b0);
    drain("ptr5");
    notes[1] = 7'd11;
    notes[6] = 7'd66;
    expect_upd(6, 1'b0);
    expect_upd(1, 1'b1);
    drain("rr16");

    // Reset during WAIT.
    notes[0] = 7'd7;
    wait_busy("wait0");
    tick(2);
    RESET = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    for (int i = 0; i < V; i++) begin
      exp_slot[i] = '0;
      expect_upd(i, i > 0);
    end
    RESET = 1'b0;
    drain("rerefresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
